// File: rtl/autocorr_engine.sv
// Autocorrelation producer for the pitch detector: r[L] = sum x[n]*x[n+L] over one frame,
// written lag by lag into the correlation array; level `done` enables the downstream finder.
module autocorr_engine #(
    parameter int FRAME_LEN = 480,
    parameter int LAG_MIN   = 47,
    parameter int LAG_MAX   = 141,
    parameter int SAMPLE_W  = 16,
    parameter int ACC_W     = 72
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       start,
    output logic [9:0]                 samp_addr_a,
    output logic [9:0]                 samp_addr_b,
    input  logic signed [SAMPLE_W-1:0] samp_data_a,
    input  logic signed [SAMPLE_W-1:0] samp_data_b,
    output logic                       res_we,
    output logic [9:0]                 res_addr,
    output logic signed [ACC_W-1:0]    res_data,
    output logic                       busy,
    output logic                       done
);

    localparam int PROD_W = 2 * SAMPLE_W;
    localparam logic [9:0] LAST_ADDR = 10'(FRAME_LEN - 1);
    localparam logic [9:0] LAG_FIRST = 10'(LAG_MIN);
    localparam logic [9:0] LAG_LAST  = 10'(LAG_MAX);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

    state_t                    state, state_nxt;
    logic [9:0]                lag;
    logic                      drain_cnt;
    logic                      data_vld, prod_vld;
    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   acc, acc_sum;
    logic                      last_issue;

    assign last_issue = (samp_addr_b == LAST_ADDR);

    // Only products backed by a real ISSUE cycle are accumulated.
    assign acc_sum = acc + (prod_vld ? {{(ACC_W-PROD_W){product[PROD_W-1]}}, product}
                                     : {ACC_W{1'b0}});

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = ISSUE;
            ISSUE: begin
                busy = 1'b1;
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                state_nxt = (lag == LAG_LAST) ? DONE : ISSUE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The result registers are loaded on the last DRAIN edge so they show r[L] during WRITE
    // and then hold it until the next lag is written.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            samp_addr_a <= '0;
            samp_addr_b <= '0;
            lag         <= '0;
            drain_cnt   <= 1'b0;
            data_vld    <= 1'b0;
            prod_vld    <= 1'b0;
            product     <= '0;
            acc         <= '0;
            res_we      <= 1'b0;
            res_addr    <= '0;
            res_data    <= '0;
        end else begin
            data_vld <= (state == ISSUE);
            prod_vld <= data_vld;
            product  <= samp_data_a * samp_data_b;
            res_we   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lag         <= LAG_FIRST;
                        samp_addr_a <= '0;
                        samp_addr_b <= LAG_FIRST;
                        acc         <= '0;
                    end
                end
                ISSUE: begin
                    acc       <= acc_sum;
                    drain_cnt <= 1'b0;
                    if (!last_issue) begin
                        samp_addr_a <= samp_addr_a + 10'd1;
                        samp_addr_b <= samp_addr_b + 10'd1;
                    end
                end
                DRAIN: begin
                    acc       <= acc_sum;
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        res_we   <= 1'b1;
                        res_addr <= lag;
                        res_data <= acc_sum;
                    end
                end
                WRITE: begin
                    acc <= '0;
                    if (lag != LAG_LAST) begin
                        lag         <= lag + 10'd1;
                        samp_addr_a <= '0;
                        samp_addr_b <= lag + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_autocorr_engine.sv
// Randomized self-checking bench for autocorr_engine: a full-size instance for timing, reset and
// worst-case magnitude, plus a reduced-frame instance for many quick frames against a reference sum.
module tb_autocorr_engine;

    localparam int N_F = 480, LMIN_F = 47, LMAX_F = 141;
    localparam int N_S = 64,  LMIN_S = 5,  LMAX_S = 20;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic start_f = 1'b0, start_s = 1'b0;

    logic [9:0]          f_addr_a, f_addr_b, f_raddr, s_addr_a, s_addr_b, s_raddr;
    logic signed [15:0]  f_da, f_db, s_da, s_db;
    logic                f_we, f_busy, f_done, s_we, s_busy, s_done;
    logic signed [71:0]  f_rdata, s_rdata;

    logic signed [15:0]  mem [0:479];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int cur_n = N_S;
    bit sel_full = 1'b0;

    int                 wr_addr[$];
    logic signed [71:0] wr_data[$];
    int                 wr_cyc[$];

    autocorr_engine dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start_f),
        .samp_addr_a(f_addr_a), .samp_addr_b(f_addr_b),
        .samp_data_a(f_da), .samp_data_b(f_db),
        .res_we(f_we), .res_addr(f_raddr), .res_data(f_rdata),
        .busy(f_busy), .done(f_done)
    );

    autocorr_engine #(.FRAME_LEN(N_S), .LAG_MIN(LMIN_S), .LAG_MAX(LMAX_S)) dut_small (
        .Clk(Clk), .Reset_n(Reset_n), .start(start_s),
        .samp_addr_a(s_addr_a), .samp_addr_b(s_addr_b),
        .samp_data_a(s_da), .samp_data_b(s_db),
        .res_we(s_we), .res_addr(s_raddr), .res_data(s_rdata),
        .busy(s_busy), .done(s_done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc  <= cyc + 1;
        f_da <= (f_addr_a < 10'd480) ? mem[f_addr_a] : 16'sd0;
        f_db <= (f_addr_b < 10'd480) ? mem[f_addr_b] : 16'sd0;
        s_da <= (s_addr_a < 10'd480) ? mem[s_addr_a] : 16'sd0;
        s_db <= (s_addr_b < 10'd480) ? mem[s_addr_b] : 16'sd0;
    end

    logic               m_we, m_busy, m_done;
    logic [9:0]         m_raddr, m_addr_a, m_addr_b;
    logic signed [71:0] m_rdata;
    assign m_we     = sel_full ? f_we     : s_we;
    assign m_busy   = sel_full ? f_busy   : s_busy;
    assign m_done   = sel_full ? f_done   : s_done;
    assign m_raddr  = sel_full ? f_raddr  : s_raddr;
    assign m_rdata  = sel_full ? f_rdata  : s_rdata;
    assign m_addr_a = sel_full ? f_addr_a : s_addr_a;
    assign m_addr_b = sel_full ? f_addr_b : s_addr_b;

    // Write log plus protocol watch: writes only while busy, never busy and done together,
    // read addresses always inside the frame.
    always @(negedge Clk) begin
        if (m_we === 1'b1) begin
            wr_addr.push_back(int'(m_raddr));
            wr_data.push_back(m_rdata);
            wr_cyc.push_back(cyc);
        end
        if (m_we === 1'b1 && m_busy !== 1'b1) viol++;
        if (m_busy === 1'b1 && m_done === 1'b1) viol++;
        if (m_busy === 1'b1 && (int'(m_addr_b) >= cur_n || m_addr_a > m_addr_b)) viol++;
    end

    task automatic checkOutput(input string tag, input logic signed [71:0] obs,
                               input logic signed [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint refCorr(input int lag, input int nlen);
        longint s = 0;
        for (int n = 0; n + lag < nlen; n++)
            s += longint'(mem[n]) * longint'(mem[n + lag]);
        return s;
    endfunction

    // kind: 0 zero, 1 constant one, 2 impulse train, 3 all -32768, 4 random full range,
    // 5 random small, 6 random with extremes mixed in
    task automatic loadFrame(input int kind, input int period);
        for (int i = 0; i < 480; i++) begin
            case (kind)
                0: mem[i] = 16'sd0;
                1: mem[i] = 16'sd1;
                2: mem[i] = (i % period == 0) ? 16'sd1000 : 16'sd0;
                3: mem[i] = -16'sd32768;
                4: mem[i] = 16'($urandom);
                5: mem[i] = 16'(int'($urandom_range(0, 200)) - 100);
                default: begin
                    case ($urandom_range(0, 2))
                        0: mem[i] = -16'sd32768;
                        1: mem[i] = 16'sd32767;
                        default: mem[i] = 16'($urandom);
                    endcase
                end
            endcase
        end
    endtask

    task automatic driveStart(input bit full, input logic v);
        if (full) start_f = v;
        else      start_s = v;
    endtask

    task automatic applyStimulus(input bit full, input int kind, input int period,
                                 input int pulse1, input int pulse2);
        int nlen, lmin, lmax, total, start_cyc, rel, exp_cyc, idx;
        nlen = full ? N_F : N_S;
        lmin = full ? LMIN_F : LMIN_S;
        lmax = full ? LMAX_F : LMAX_S;
        total = 0;
        for (int l = lmin; l <= lmax; l++) total += nlen - l + 3;
        sel_full = full;
        cur_n = nlen;
        loadFrame(kind, period);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        viol = 0;

        @(negedge Clk);
        start_cyc = cyc;
        driveStart(full, 1'b1);
        @(negedge Clk);
        driveStart(full, 1'b0);
        checkOutput("done_low_cycle1", m_done, 0);
        checkOutput("busy_cycle1", m_busy, 1);

        rel = 1;
        while (m_done !== 1'b1 && rel <= total + 10) begin
            @(negedge Clk);
            rel = cyc - start_cyc;
            driveStart(full, (rel == pulse1 || rel == pulse2) ? 1'b1 : 1'b0);
        end
        driveStart(full, 1'b0);
        checkOutput("done_seen", m_done, 1);
        checkOutput("done_cycle", cyc - start_cyc, total + 1);
        checkOutput("busy_at_done", m_busy, 0);
        checkOutput("hold_addr", m_raddr, lmax);
        checkOutput("hold_data", m_rdata, refCorr(lmax, nlen));

        repeat (5) @(negedge Clk);
        checkOutput("done_stays", m_done, 1);
        checkOutput("n_writes", wr_addr.size(), lmax - lmin + 1);
        exp_cyc = 0;
        for (int l = lmin; l <= lmax; l++) begin
            exp_cyc += nlen - l + 3;
            idx = l - lmin;
            if (idx < wr_addr.size()) begin
                checkOutput($sformatf("waddr[%0d]", l), wr_addr[idx], l);
                checkOutput($sformatf("wdata[%0d]", l), wr_data[idx], refCorr(l, nlen));
                checkOutput($sformatf("wcycle[%0d]", l), wr_cyc[idx] - start_cyc, exp_cyc);
            end
        end
        checkOutput("protocol", viol, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_cyc;
        loadFrame(0, 1);
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("rst_f_busy", f_busy, 0);
        checkOutput("rst_f_done", f_done, 0);
        checkOutput("rst_f_we", f_we, 0);
        checkOutput("rst_f_raddr", f_raddr, 0);
        checkOutput("rst_f_rdata", f_rdata, 0);
        checkOutput("rst_f_addr_a", f_addr_a, 0);
        checkOutput("rst_f_addr_b", f_addr_b, 0);
        checkOutput("rst_s_busy", s_busy, 0);
        checkOutput("rst_s_done", s_done, 0);
        checkOutput("rst_s_we", s_we, 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        applyStimulus(1'b0, 0, 1, 10, 400);
        applyStimulus(1'b0, 1, 1, 10, 400);
        if (wr_data.size() > 0) checkOutput("const_res_first", wr_data[0], N_S - LMIN_S);
        applyStimulus(1'b0, 2, 10, 10, 400);
        if (wr_data.size() > 5) checkOutput("impulse_res10", wr_data[5], 6_000_000);
        applyStimulus(1'b0, 3, 1, 10, 400);
        applyStimulus(1'b0, 4, 1, 10, 400);
        applyStimulus(1'b0, 4, 1, 10, 400);
        applyStimulus(1'b0, 5, 1, 10, 400);
        applyStimulus(1'b0, 6, 1, 10, 400);

        // Full-size run aborted by reset at cycle 1000: only lags 47 and 48 get written.
        sel_full = 1'b1;
        cur_n = N_F;
        loadFrame(4, 1);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        @(negedge Clk);
        start_cyc = cyc;
        start_f = 1'b1;
        @(negedge Clk);
        start_f = 1'b0;
        while (cyc - start_cyc < 1000) @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        checkOutput("abort_busy", f_busy, 0);
        checkOutput("abort_done", f_done, 0);
        checkOutput("abort_we", f_we, 0);
        repeat (1000) @(negedge Clk);
        checkOutput("abort_n_writes", wr_addr.size(), 2);
        checkOutput("abort_idle_busy", f_busy, 0);

        applyStimulus(1'b1, 3, 1, 10, 20000);
        if (wr_data.size() > 0) checkOutput("worst_res47", wr_data[0], 72'sd464930209792);

        start_f = 1'b1;
        @(negedge Clk);
        start_f = 1'b0;
        checkOutput("restart_done_low", f_done, 0);
        checkOutput("restart_busy", f_busy, 1);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/autocorr_engine.md
Name: autocorr_engine

Overview:
- Producer side of the pitch-detection datapath. Computes the autocorrelation r[L] = sum over n of x[n]*x[n+L] of one sample frame, for lags LAG_MIN..LAG_MAX.
- Writes each lag result into the correlation array read by the peak/pitch finder.
- Its level `done` output drives the finder's `shouldFind` enable directly.
- Samples come from a dual-read-port frame RAM.

Parameters:
- FRAME_LEN, 480, samples per frame (N); also the depth of the correlation array.
- LAG_MIN, 47, first lag computed.
- LAG_MAX, 141, last lag computed.
- SAMPLE_W, 16, signed sample width.
- ACC_W, 72, signed accumulator and result width; matches the correlation array entries.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to process the current frame; honoured only when not busy.
- samp_addr_a  out  10  read address, port A (x[n]).
- samp_addr_b  out  10  read address, port B (x[n+L]).
- samp_data_a  in  SAMPLE_W  signed RAM data A, valid 1 cycle after address.
- samp_data_b  in  SAMPLE_W  signed RAM data B, valid 1 cycle after address.
- res_we  out  1  result write strobe, one cycle per lag.
- res_addr  out  10  lag index L being written.
- res_data  out  ACC_W  signed r[L].
- busy  out  1  high from first address issue through final write.
- done  out  1  results valid; feeds the finder's shouldFind.

Behaviour:
- Reset, sampled on a rising edge with Reset_n low, forces next-cycle values:
  - state IDLE;
  - busy=0, done=0, res_we=0;
  - res_addr=0, res_data=0, samp_addr_a=0, samp_addr_b=0;
  - accumulator cleared.
- Reset mid-run aborts immediately. No further writes; already-written lags are left as-is.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 -> ISSUE with L=LAG_MIN, n=0, acc=0; done drops to 0.
  - Call the start-sampling cycle "cycle 0".
- ISSUE: one cycle per n, n = 0..FRAME_LEN-1-L.
  - Drive samp_addr_a=n, samp_addr_b=n+L.
  - samp_addr_b never exceeds FRAME_LEN-1; no wrap-around, no zero padding.
  - Leave to DRAIN after n = FRAME_LEN-1-L.
- Datapath pipeline:
  - Stage 1 (cycle after address): product = samp_data_a * samp_data_b, full signed 2*SAMPLE_W bits, registered.
  - Stage 2: acc += sign-extended product.
  - No saturation is needed: ACC_W cannot overflow for N=480, 16-bit samples.
- DRAIN: 2 cycles, letting the last product reach the accumulator.
- WRITE: 1 cycle.
  - res_we=1, res_addr=L, res_data=acc; acc is cleared in the same cycle.
  - If L<LAG_MAX: L+1 -> ISSUE with n=0.
  - Else -> DONE.
- Cycle budget:
  - Each lag occupies exactly FRAME_LEN-L+3 cycles. The first ISSUE cycle is cycle 1.
  - With defaults: 95 writes, final write in cycle 36955, done=1 from cycle 36956.
- DONE:
  - done=1, busy=0; results held stable in the array (engine issues no writes).
  - start=1 restarts: done drops to 0 the next cycle and the sequence repeats.
- busy=1 exactly in ISSUE/DRAIN/WRITE.
- start while busy is ignored and has no effect on timing.
- res_we is never asserted outside WRITE. Lags outside LAG_MIN..LAG_MAX are never written.
- Outputs res_addr/res_data hold their last written values when res_we=0.

Test Plan:
- All-zero frame, start pulse:
  - exactly 95 writes, res_addr 47,48,…,141 in order, all res_data=0;
  - done rises at cycle 36956; busy=0 afterwards.
- Constant x[n]=1:
  - res[L]=480-L: res[47]=433, res[100]=380, res[141]=339;
  - the downstream finder enabled by done reports pitch 12000/47=255.
- Impulse train x[n]=1000 at n mod 100==0, else 0:
  - res[100]=4,000,000, all other lags 0;
  - finder reports pitch 120.
- Worst-case magnitude, all x[n]=-32768:
  - res[47]=433*2^30=464,930,209,792, positive;
  - no overflow or sign error at any lag.
- Reset_n low at cycle 1000 for one cycle:
  - next cycle busy=0, done=0, res_we=0, no further writes;
  - a new start then completes normally with correct results and the 36955-cycle timing.
- start re-pulsed at cycles 10 and 20000 during a run:
  - ignored, timing unchanged;
  - start in DONE restarts, done=0 the following cycle.
